cache_memory_arbiter: RTL and testbench
=======================================

# cache_memory_arbiter

Shares the single physical-memory line port between the instruction cache and the data cache. The data cache sits behind the load/store reservation station. The block accepts 256-bit line read requests from the I-cache and line read/write requests from the D-cache. It serialises them onto the memory port with an alternating-priority FSM and routes each response back only to the requester that owns the transaction. It sits between the two caches and the memory model/L2, and keeps per-requester grant counters for performance reporting.

## Interface
Parameters:
- `line_bits`, 256: cache line width.
- `offset_bits`, 5: line offset width; these low address bits are cleared on the memory port.

Ports:
- `clk`  in  1  sole clock; all state updates on posedge.
- `rst`  in  1  reset, asynchronous, active-high.
- `i_read`  in  1  I-cache line read request; held until `i_resp`.
- `i_address`  in  32  I-cache request address.
- `i_rdata`  out  line_bits  line returned to the I-cache.
- `i_resp`  out  1  one-cycle completion pulse to the I-cache.
- `d_read`, `d_write`  in  1 each  D-cache request; held until `d_resp`.
- `d_address`  in  32  D-cache request address.
- `d_wdata`  in  line_bits  D-cache write line.
- `d_rdata`  out  line_bits  line returned to the D-cache.
- `d_resp`  out  1  one-cycle completion pulse to the D-cache.
- `pmem_read`, `pmem_write`  out  1 each  memory commands; held until `pmem_resp`.
- `pmem_address`  out  32  line-aligned address.
- `pmem_wdata`  out  line_bits  write line to memory.
- `pmem_rdata`  in  line_bits  read line from memory.
- `pmem_resp`  in  1  memory completion pulse.
- `i_grant_count`, `d_grant_count`  out  32 each  completed transactions per requester.

## Operation
- FSM states:
  - `ARB_IDLE`: no memory command driven.
  - `ARB_ICACHE`: serving an I-cache read.
  - `ARB_DCACHE`: serving a D-cache read or write.
- In `ARB_IDLE`, the requester with a pending request wins:
  - Only one pending: that requester wins.
  - Both pending: the requester not equal to `last_grant` wins.
  - `last_grant` resets to D-cache, so the first tie after reset goes to the I-cache.
- On grant, latch into registers:
  - address with the low `offset_bits` forced to 0;
  - `d_wdata`;
  - op: D-cache write if `d_write`=1; `d_write` takes precedence if both `d_read` and `d_write` are high.
  - Update `last_grant`.
- In the serve state:
  - Drive `pmem_read` or `pmem_write`, `pmem_address` and `pmem_wdata` from the latched registers only.
  - Changes on requester inputs during a transaction are ignored.
- When `pmem_resp`=1 in the serve state:
  - Pulse the owner's `*_resp` combinationally in the same cycle.
  - Increment the owner's grant counter (32-bit wrap).
  - Next state is `ARB_IDLE`.
- `i_rdata` and `d_rdata` are a continuous pass-through of `pmem_rdata`; only `*_resp` is gated.
- `pmem_resp` arriving in `ARB_IDLE` is ignored: no resp, no count.
- A requester dropping its request mid-transaction is ignored; the transaction completes and its resp still pulses.

## Timing
- Reset (asynchronous, any state) sets these immediately, without waiting for a clock edge:
  - state = `ARB_IDLE`;
  - `pmem_read` = `pmem_write` = `i_resp` = `d_resp` = 0;
  - both counters = 0;
  - `last_grant` = D-cache;
  - latched address/wdata = 0.
- A transaction in flight at reset is abandoned, with no resp.
- Cycle 0: request seen in `ARB_IDLE`; grant is registered at the edge.
- Cycle 1: `pmem_*` command asserted.
- Cycle k: `pmem_resp` → owner resp in cycle k. Latency to resp is k cycles; minimum 2.
- Back-to-back transactions: exactly one `ARB_IDLE` cycle between the resp cycle and the next command.
- Maximum wait for a requester under contention is one full transaction of the other requester.

## Structure
- Shared package (`rv32i_types`):
  - `arb_state_t` enum {`ARB_IDLE`, `ARB_ICACHE`, `ARB_DCACHE`};
  - `arb_req_t` enum {`REQ_I`, `REQ_D`}.
- Single module, no sub-module; the two-way priority pick is a few lines of combinational logic.
- Separate always_comb blocks for next-state/grant decode and output decode.
- One always_ff with asynchronous reset.

## Test plan
- **Reset mid-transaction:**
  - Stimulus: assert `rst` asynchronously while `pmem_read`=1.
  - Required: `pmem_read`, `i_resp` and `d_resp` drop before the next edge; counters read 0.
  - After reset release, a new `i_read` is served.
- **Lone I-cache read:**
  - Stimulus: `i_address`=0x0000_1234; memory responds 3 cycles after command with line 0xA5..A5.
  - Required:
    - `pmem_address`=0x0000_1220;
    - `i_resp` pulses once with `i_rdata`=0xA5..A5;
    - `d_resp` stays 0;
    - `i_grant_count`=1.
- **Simultaneous requests after reset:**
  - Stimulus: `i_read` and `d_write` asserted at cycle 0.
  - Required: I-cache is served first, then D-cache; `pmem_write`=1 with the latched `d_wdata`; one idle cycle between the two transactions.
- **Sustained contention:**
  - Stimulus: both requesters re-request immediately after each resp, for 10 transactions.
  - Required: strict alternation I,D,I,D…; both counters = 5.
- **Input perturbation during transaction:**
  - Stimulus: change `d_address` and `d_wdata` and drop `d_read` while `ARB_DCACHE` waits.
  - Required: `pmem_address` and `pmem_wdata` keep their latched values; `d_resp` still pulses.
- **Stray response:**
  - Stimulus: `pmem_resp` pulse while in `ARB_IDLE`; also `d_read`=`d_write`=1.
  - Required: the stray pulse produces no resp and no count change; the dual request issues `pmem_write` only.

Source files
------------

// File: rtl/cache_memory_arbiter_pkg.sv
// Shared arbiter types: FSM state encoding, requester identity, line alignment helper.
// Latency: none (types and a pure function only).
// Backpressure: not applicable.
package rv32i_types;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ICACHE,
    ARB_DCACHE
  } arb_state_t;

  typedef enum logic {
    REQ_I,
    REQ_D
  } arb_req_t;

  // Clear the low offset bits so the memory port always sees a line address.
  function automatic logic [31:0] line_align(input logic [31:0] addr,
                                             input int unsigned offset_bits);
    logic [31:0] mask;
    mask = 32'hFFFF_FFFF << offset_bits;
    return addr & mask;
  endfunction

endpackage

// File: rtl/cache_memory_arbiter.sv
// Serialises I-cache reads and D-cache reads/writes onto one memory line port, alternating on ties.
// Latency: grant registered in the request cycle, command next cycle, resp in the same cycle as pmem_resp.
// Backpressure: requests are held until *_resp; one idle cycle separates back-to-back transactions.
module cache_memory_arbiter
  import rv32i_types::*;
#(
  parameter int unsigned line_bits   = 256,
  parameter int unsigned offset_bits = 5
) (
  input  logic                 clk,
  input  logic                 rst,

  input  logic                 i_read,
  input  logic [31:0]          i_address,
  output logic [line_bits-1:0] i_rdata,
  output logic                 i_resp,

  input  logic                 d_read,
  input  logic                 d_write,
  input  logic [31:0]          d_address,
  input  logic [line_bits-1:0] d_wdata,
  output logic [line_bits-1:0] d_rdata,
  output logic                 d_resp,

  output logic                 pmem_read,
  output logic                 pmem_write,
  output logic [31:0]          pmem_address,
  output logic [line_bits-1:0] pmem_wdata,
  input  logic [line_bits-1:0] pmem_rdata,
  input  logic                 pmem_resp,

  output logic [31:0]          i_grant_count,
  output logic [31:0]          d_grant_count
);

  arb_state_t           state;
  arb_state_t           state_next;
  arb_req_t             last_grant;
  arb_req_t             grant_req;
  logic                 grant_vld;
  logic                 i_pend;
  logic                 d_pend;

  // Transaction registers: the memory port is driven only from these.
  logic [31:0]          addr_q;
  logic [line_bits-1:0] wdata_q;
  logic                 write_q;

  logic [31:0]          i_cnt;
  logic [31:0]          d_cnt;

  assign i_pend = i_read;
  assign d_pend = d_read | d_write;

  // Next-state and grant decode: only IDLE grants; a tie goes to whoever did not win last.
  always_comb begin
    state_next = state;
    grant_vld  = 1'b0;
    grant_req  = REQ_I;
    unique case (state)
      ARB_IDLE: begin
        if (i_pend && (!d_pend || last_grant == REQ_D)) begin
          grant_vld  = 1'b1;
          grant_req  = REQ_I;
          state_next = ARB_ICACHE;
        end else if (d_pend) begin
          grant_vld  = 1'b1;
          grant_req  = REQ_D;
          state_next = ARB_DCACHE;
        end
      end
      ARB_ICACHE, ARB_DCACHE: begin
        if (pmem_resp) begin
          state_next = ARB_IDLE;
        end
      end
      default: state_next = ARB_IDLE;
    endcase
  end

  // Output decode: memory command from latched state, resp gated to the owner.
  always_comb begin
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = addr_q;
    pmem_wdata   = wdata_q;
    i_resp       = 1'b0;
    d_resp       = 1'b0;
    unique case (state)
      ARB_ICACHE: begin
        pmem_read = 1'b1;
        i_resp    = pmem_resp;
      end
      ARB_DCACHE: begin
        pmem_read  = ~write_q;
        pmem_write = write_q;
        d_resp     = pmem_resp;
      end
      default: begin
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
      end
    endcase
  end

  // Read data is shared; only the resp pulse distinguishes the owner.
  assign i_rdata       = pmem_rdata;
  assign d_rdata       = pmem_rdata;
  assign i_grant_count = i_cnt;
  assign d_grant_count = d_cnt;

  // State, transaction latch and per-requester completion counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ARB_IDLE;
      last_grant <= REQ_D;
      addr_q     <= '0;
      wdata_q    <= '0;
      write_q    <= 1'b0;
      i_cnt      <= '0;
      d_cnt      <= '0;
    end else begin
      state <= state_next;
      if (grant_vld) begin
        last_grant <= grant_req;
        addr_q     <= line_align((grant_req == REQ_I) ? i_address : d_address, offset_bits);
        wdata_q    <= d_wdata;
        // A write wins over a read when the D-cache raises both.
        write_q    <= (grant_req == REQ_D) && d_write;
      end
      if (i_resp) begin
        i_cnt <= i_cnt + 32'd1;
      end
      if (d_resp) begin
        d_cnt <= d_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_cache_memory_arbiter.sv
// Randomised bench for the cache/memory arbiter with a transaction-level reference model.
// Latency: checks command one cycle after the request and resp in the pmem_resp cycle.
// Backpressure: memory latency is varied per transaction; requesters hold until resp.
module tb_cache_memory_arbiter;

  localparam int unsigned LB = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_read;
  logic [31:0]   i_address;
  logic [LB-1:0] i_rdata;
  logic          i_resp;
  logic          d_read;
  logic          d_write;
  logic [31:0]   d_address;
  logic [LB-1:0] d_wdata;
  logic [LB-1:0] d_rdata;
  logic          d_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic [31:0]   pmem_address;
  logic [LB-1:0] pmem_wdata;
  logic [LB-1:0] pmem_rdata;
  logic          pmem_resp;
  logic [31:0]   i_grant_count;
  logic [31:0]   d_grant_count;

  always #5 clk = ~clk;

  cache_memory_arbiter #(
    .line_bits   (LB),
    .offset_bits (5)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_read        (i_read),
    .i_address     (i_address),
    .i_rdata       (i_rdata),
    .i_resp        (i_resp),
    .d_read        (d_read),
    .d_write       (d_write),
    .d_address     (d_address),
    .d_wdata       (d_wdata),
    .d_rdata       (d_rdata),
    .d_resp        (d_resp),
    .pmem_read     (pmem_read),
    .pmem_write    (pmem_write),
    .pmem_address  (pmem_address),
    .pmem_wdata    (pmem_wdata),
    .pmem_rdata    (pmem_rdata),
    .pmem_resp     (pmem_resp),
    .i_grant_count (i_grant_count),
    .d_grant_count (d_grant_count)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: who won last, and how many completions each requester has.
  bit          m_last_d;
  int unsigned m_icnt;
  int unsigned m_dcnt;

  task automatic check_val(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [LB-1:0] rand_line();
    logic [LB-1:0] r;
    for (int k = 0; k < LB / 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic model_reset();
    m_last_d = 1'b1;
    m_icnt   = 0;
    m_dcnt   = 0;
  endtask

  task automatic req_i();
    i_read    = 1'b1;
    i_address = $urandom;
  endtask

  task automatic req_d();
    int sel;
    sel       = $urandom_range(0, 2);
    d_read    = (sel != 1);
    d_write   = (sel != 0);
    d_address = $urandom;
    d_wdata   = rand_line();
  endtask

  // Called at posedge+1 of an idle cycle with requests already driven.
  task automatic run_txn(input int lat, input bit perturb, input bit fixed,
                         input logic [LB-1:0] fixed_data);
    bit            ip;
    bit            dp;
    bit            owner_d;
    logic [31:0]   e_addr;
    bit            e_wr;
    logic [LB-1:0] e_wdata;
    logic [LB-1:0] rd;
    if (!i_read && !d_read && !d_write) req_i();
    ip      = i_read;
    dp      = d_read | d_write;
    owner_d = (ip && dp) ? !m_last_d : dp;
    e_addr  = (owner_d ? d_address : i_address) & 32'hFFFF_FFE0;
    e_wr    = owner_d && d_write;
    e_wdata = d_wdata;
    rd      = '0;

    @(negedge clk);
    check_val("idle_pmem_read", 256'(pmem_read), 256'(1'b0));
    check_val("idle_pmem_write", 256'(pmem_write), 256'(1'b0));
    check_val("i_grant_count", 256'(i_grant_count), 256'(m_icnt));
    check_val("d_grant_count", 256'(d_grant_count), 256'(m_dcnt));

    @(posedge clk); #1;
    @(negedge clk);
    check_val("cmd_read", 256'(pmem_read), 256'(!e_wr));
    check_val("cmd_write", 256'(pmem_write), 256'(e_wr));
    check_val("cmd_address", 256'(pmem_address), 256'(e_addr));
    if (e_wr) check_val("cmd_wdata", 256'(pmem_wdata), 256'(e_wdata));

    for (int j = 0; j < lat; j++) begin
      @(posedge clk); #1;
      if (perturb) begin
        if (owner_d) begin
          d_address = $urandom;
          d_wdata   = rand_line();
          d_read    = 1'b0;
          d_write   = 1'($urandom_range(0, 1));
        end else begin
          i_address = $urandom;
          i_read    = 1'b0;
        end
      end
      if (j == lat - 1) begin
        rd         = fixed ? fixed_data : rand_line();
        pmem_rdata = rd;
        pmem_resp  = 1'b1;
      end
      @(negedge clk);
      check_val("hold_address", 256'(pmem_address), 256'(e_addr));
      check_val("hold_write", 256'(pmem_write), 256'(e_wr));
      check_val("hold_read", 256'(pmem_read), 256'(!e_wr));
      if (e_wr) check_val("hold_wdata", 256'(pmem_wdata), 256'(e_wdata));
      if (j < lat - 1) begin
        check_val("early_i_resp", 256'(i_resp), 256'(1'b0));
        check_val("early_d_resp", 256'(d_resp), 256'(1'b0));
      end else begin
        check_val("i_resp", 256'(i_resp), 256'(!owner_d));
        check_val("d_resp", 256'(d_resp), 256'(owner_d));
        check_val("i_rdata", 256'(i_rdata), 256'(rd));
        check_val("d_rdata", 256'(d_rdata), 256'(rd));
      end
    end

    @(posedge clk); #1;
    pmem_resp = 1'b0;
    if (owner_d) begin
      d_read  = 1'b0;
      d_write = 1'b0;
      m_dcnt++;
    end else begin
      i_read = 1'b0;
      m_icnt++;
    end
    m_last_d = owner_d;
  endtask

  task automatic stray_resp();
    pmem_resp  = 1'b1;
    pmem_rdata = rand_line();
    @(negedge clk);
    check_val("stray_i_resp", 256'(i_resp), 256'(1'b0));
    check_val("stray_d_resp", 256'(d_resp), 256'(1'b0));
    @(posedge clk); #1;
    pmem_resp = 1'b0;
  endtask

  initial begin
    int unsigned i0;
    int unsigned d0;
    rst        = 1'b1;
    i_read     = 1'b0;
    i_address  = '0;
    d_read     = 1'b0;
    d_write    = 1'b0;
    d_address  = '0;
    d_wdata    = '0;
    pmem_rdata = '0;
    pmem_resp  = 1'b0;
    model_reset();

    #12;
    check_val("rst_pmem_read", 256'(pmem_read), 256'(1'b0));
    check_val("rst_pmem_write", 256'(pmem_write), 256'(1'b0));
    check_val("rst_i_count", 256'(i_grant_count), 256'(0));
    check_val("rst_d_count", 256'(d_grant_count), 256'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    // Lone I-cache read with a fixed pattern and three-cycle memory latency.
    i_read    = 1'b1;
    i_address = 32'h0000_1234;
    run_txn(3, 1'b0, 1'b1, {32{8'hA5}});
    check_val("lone_i_count", 256'(i_grant_count), 256'(1));
    check_val("lone_d_count", 256'(d_grant_count), 256'(0));

    // Asynchronous reset while a read command is on the port.
    req_i();
    @(posedge clk); #1;
    @(negedge clk);
    check_val("pre_rst_cmd", 256'(pmem_read), 256'(1'b1));
    #2;
    pmem_resp = 1'b1;
    rst       = 1'b1;
    #1;
    check_val("async_rst_read", 256'(pmem_read), 256'(1'b0));
    check_val("async_rst_i_resp", 256'(i_resp), 256'(1'b0));
    check_val("async_rst_d_resp", 256'(d_resp), 256'(1'b0));
    check_val("async_rst_i_count", 256'(i_grant_count), 256'(0));
    check_val("async_rst_d_count", 256'(d_grant_count), 256'(0));
    pmem_resp = 1'b0;
    i_read    = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();

    // Simultaneous I read and D write straight after reset: I first, then D.
    i_read    = 1'b1;
    i_address = $urandom;
    d_read    = 1'b0;
    d_write   = 1'b1;
    d_address = $urandom;
    d_wdata   = rand_line();
    run_txn($urandom_range(1, 3), 1'b0, 1'b0, '0);
    check_val("tie_first_is_i", 256'(i_grant_count), 256'(1));
    run_txn($urandom_range(1, 3), 1'b0, 1'b0, '0);
    check_val("tie_then_d", 256'(d_grant_count), 256'(1));

    // D read whose inputs move and drop while memory is busy.
    d_read    = 1'b1;
    d_write   = 1'b0;
    d_address = $urandom;
    d_wdata   = rand_line();
    run_txn(4, 1'b1, 1'b0, '0);

    // Stray memory response while idle, then a read+write D request.
    stray_resp();
    d_read    = 1'b1;
    d_write   = 1'b1;
    d_address = $urandom;
    d_wdata   = rand_line();
    run_txn(2, 1'b0, 1'b0, '0);

    // Sustained contention: ten back-to-back transactions must split evenly.
    i0 = m_icnt;
    d0 = m_dcnt;
    req_i();
    req_d();
    for (int t = 0; t < 10; t++) begin
      run_txn($urandom_range(1, 4), 1'b0, 1'b0, '0);
      if (!i_read) req_i();
      if (!d_read && !d_write) req_d();
    end
    check_val("contend_i_count", 256'(i_grant_count), 256'(i0 + 5));
    check_val("contend_d_count", 256'(d_grant_count), 256'(d0 + 5));

    // Random traffic.
    for (int t = 0; t < 60; t++) begin
      if (!i_read && !d_read && !d_write && $urandom_range(0, 3) == 0) stray_resp();
      if (!i_read && $urandom_range(0, 1) == 1) req_i();
      if (!d_read && !d_write && $urandom_range(0, 1) == 1) req_d();
      run_txn($urandom_range(1, 4), 1'($urandom_range(0, 1)), 1'b0, '0);
    end
    @(negedge clk);
    check_val("final_i_count", 256'(i_grant_count), 256'(m_icnt));
    check_val("final_d_count", 256'(d_grant_count), 256'(m_dcnt));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
